// File: rtl/cdb_tag_drain_pkg.sv
// Shared constants and types for the CDB tag drain: default widths, drain FSM states and the
// broadcast packet layout.
package cdb_tag_drain_pkg;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TAG_WIDTH  = 4;
    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StCheck = 2'd1;
    localparam logic [1:0] StSend  = 2'd2;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_tag_drain_occ.sv
// Occupancy tracker for the paired tag queue, built from the observed push strobe and the
// drain's own pop strobe. Pushes that arrive while full are dropped and flagged as overflow.
module cdb_tag_drain_occ #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_seen,
    input  logic                        pop,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        empty,
    output logic                        full,
    output logic                        overflow
);

    localparam int unsigned CountWidth = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CountWidth-1:0] Depth = CountWidth'(FIFO_DEPTH);

    logic [CountWidth-1:0] count_q, count_d;
    logic                  ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        case ({push_seen, pop})
            2'b10: begin
                if (count_q == Depth) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + CountWidth'(1);
                end
            end
            2'b01:   count_d = count_q - CountWidth'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == Depth);
    assign overflow = ovf_q;

endmodule

// File: rtl/cdb_tag_drain.sv
// Consumer end of the in-order tag queue: waits for the head tag's result, broadcasts it on the
// CDB with a valid/ready handshake, then pops the queue and acks the producing RS entry.
module cdb_tag_drain #(
    parameter int unsigned FIFO_DEPTH = cdb_tag_drain_pkg::FIFO_DEPTH,
    parameter int unsigned TAG_WIDTH  = cdb_tag_drain_pkg::TAG_WIDTH,
    parameter int unsigned DATA_WIDTH = cdb_tag_drain_pkg::DATA_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  push_seen,
    input  logic [TAG_WIDTH-1:0]                  front_tag,
    input  logic [(2**TAG_WIDTH)-1:0]             rs_done,
    input  logic [(2**TAG_WIDTH)*DATA_WIDTH-1:0]  rs_result,
    output logic                                  pop,
    output logic [(2**TAG_WIDTH)-1:0]             rs_ack,
    output logic                                  cdb_valid,
    input  logic                                  cdb_ready,
    output logic [TAG_WIDTH-1:0]                  cdb_tag,
    output logic [DATA_WIDTH-1:0]                 cdb_data,
    output logic [$clog2(FIFO_DEPTH):0]           count,
    output logic                                  empty,
    output logic                                  full,
    output logic                                  overflow
);

    import cdb_tag_drain_pkg::*;

    localparam int unsigned NumTags    = 2**TAG_WIDTH;
    localparam int unsigned CountWidth = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]            state_q, state_d;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] head_data;
    logic [NumTags-1:0]    ack_onehot;
    logic                  head_done;
    logic                  accept;

    always_comb begin
        head_data  = '0;
        ack_onehot = '0;
        for (int t = 0; t < NumTags; t++) begin
            if (front_tag == TAG_WIDTH'(t)) begin
                head_data = rs_result[t*DATA_WIDTH +: DATA_WIDTH];
            end
            ack_onehot[t] = (tag_q == TAG_WIDTH'(t));
        end
    end

    assign head_done = rs_done[front_tag];
    assign cdb_valid = (state_q == StSend);
    // A handshake landing on a reset cycle is abandoned: no pop, no ack.
    assign accept    = cdb_valid && cdb_ready && !reset;
    assign pop       = accept;
    assign rs_ack    = accept ? ack_onehot : '0;
    assign cdb_tag   = tag_q;
    assign cdb_data  = data_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (!empty) state_d = StCheck;
            StCheck: if (head_done) state_d = StSend;
            StSend: begin
                // count >= 1 here, so occupancy after the pop is non-zero unless count was 1
                // and nothing new arrived this cycle.
                if (accept) begin
                    state_d = (count != CountWidth'(1) || push_seen) ? StCheck : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StCheck && head_done) begin
                tag_q  <= front_tag;
                data_q <= head_data;
            end
        end
    end

    cdb_tag_drain_occ #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_occ (
        .clk       (clk),
        .reset     (reset),
        .push_seen (push_seen),
        .pop       (pop),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_cdb_tag_drain.sv
// Bench for cdb_tag_drain: paired tag queue, directed scenarios and a randomized run, all
// checked against an in-order scoreboard of pushed tags.
module tb_cdb_tag_drain;

    localparam int FD = 4;
    localparam int TW = 4;
    localparam int DW = 32;
    localparam int NT = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           push_seen;
    logic [TW-1:0]  push_tag;
    logic [TW-1:0]  front_tag;
    logic [NT-1:0]  rs_done;
    logic [NT*DW-1:0] rs_result;
    logic           pop;
    logic [NT-1:0]  rs_ack;
    logic           cdb_valid;
    logic           cdb_ready;
    logic [TW-1:0]  cdb_tag;
    logic [DW-1:0]  cdb_data;
    logic [2:0]     count;
    logic           empty;
    logic           full;
    logic           overflow;

    logic [DW-1:0]  res [NT];

    always #5 clk = ~clk;

    always_comb begin
        rs_result = '0;
        for (int t = 0; t < NT; t++) rs_result[t*DW +: DW] = res[t];
    end

    // Paired tag queue: head visible combinationally, writes ignored while full.
    logic [TW-1:0] qmem [FD];
    logic [1:0]    q_wp, q_rp;
    int            q_cnt;
    logic          q_push_ok;

    assign q_push_ok = push_seen && (q_cnt < FD || pop);
    assign front_tag = qmem[q_rp];

    always @(posedge clk) begin
        if (reset) begin
            q_wp  <= '0;
            q_rp  <= '0;
            q_cnt <= 0;
            for (int i = 0; i < FD; i++) qmem[i] <= '0;
        end else begin
            if (q_push_ok) begin
                qmem[q_wp] <= push_tag;
                q_wp       <= q_wp + 2'd1;
            end
            if (pop) q_rp <= q_rp + 2'd1;
            q_cnt <= q_cnt + (q_push_ok ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    cdb_tag_drain #(
        .FIFO_DEPTH (FD),
        .TAG_WIDTH  (TW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .push_seen (push_seen),
        .front_tag (front_tag),
        .rs_done   (rs_done),
        .rs_result (rs_result),
        .pop       (pop),
        .rs_ack    (rs_ack),
        .cdb_valid (cdb_valid),
        .cdb_ready (cdb_ready),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_q[$];
    bit   model_ovf = 1'b0;
    bit   chk_en = 1'b0;
    int   pop_cyc[$];
    int   pop_tag[$];
    int   valid_rise = -1;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock: inputs were set at the preceding negedge; sample, update model, advance.
    task automatic step();
        #1;
        if (chk_en) begin
            check("count", 64'(count), 64'(exp_q.size()));
            check("empty", 64'(empty), 64'(exp_q.size() == 0));
            check("full", 64'(full), 64'(exp_q.size() == FD));
            check("overflow", 64'(overflow), 64'(model_ovf));
            if (reset) begin
                check("rst_no_pop", 64'(pop), 64'(0));
                check("rst_no_ack", 64'(rs_ack), 64'(0));
            end else begin
                check("pop_handshake", 64'(pop), 64'(cdb_valid && cdb_ready));
                if (pop) begin
                    if (exp_q.size() > 0) begin
                        check("cdb_tag", 64'(cdb_tag), 64'(exp_q[0]));
                        check("cdb_data", 64'(cdb_data), 64'(res[exp_q[0]]));
                        check("rs_ack", 64'(rs_ack), 64'(16'(1) << exp_q[0]));
                    end else begin
                        check("pop_when_empty", 64'(pop), 64'(0));
                    end
                    pop_cyc.push_back(cyc);
                    pop_tag.push_back(int'(cdb_tag));
                end else begin
                    check("ack_idle", 64'(rs_ack), 64'(0));
                end
            end
        end
        if (cdb_valid && !prev_valid) valid_rise = cyc;
        prev_valid = cdb_valid;
        if (reset) begin
            exp_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (push_seen) begin
                if (exp_q.size() == FD && !pop) model_ovf = 1'b1;
                else exp_q.push_back(int'(push_tag));
            end
            if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic push(input int t);
        push_seen = 1'b1;
        push_tag  = TW'(t);
        step();
        push_seen = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!cdb_valid && k < 20) begin
            step();
            k++;
        end
        check(name, 64'(cdb_valid), 64'(1));
    endtask

    initial begin
        int n;
        int pushes;
        reset     = 1'b1;
        push_seen = 1'b0;
        push_tag  = '0;
        rs_done   = '0;
        cdb_ready = 1'b0;
        for (int t = 0; t < NT; t++) res[t] = $urandom;
        @(negedge clk);
        run(2);
        reset  = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_valid", 64'(cdb_valid), 64'(0));
        check("rst_tag", 64'(cdb_tag), 64'(0));
        check("rst_data", 64'(cdb_data), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));

        // Single tag, ready held high: broadcast three cycles after the push.
        res[5] = 32'hDEAD_BEEF;
        rs_done[5] = 1'b1;
        cdb_ready = 1'b1;
        pop_cyc.delete();
        pop_tag.delete();
        valid_rise = -1;
        n = cyc;
        push(5);
        run(5);
        check("t1_valid_lat", 64'(valid_rise), 64'(n + 3));
        check("t1_pops", 64'(pop_cyc.size()), 64'(1));
        if (pop_cyc.size() >= 1) check("t1_pop_lat", 64'(pop_cyc[0]), 64'(n + 3));
        check("t1_empty", 64'(empty), 64'(1));

        // Head not done blocks a younger done tag.
        rs_done = '0;
        pop_cyc.delete();
        pop_tag.delete();
        push(3);
        push(7);
        rs_done[7] = 1'b1;
        run(10);
        check("t2_no_early", 64'(pop_cyc.size()), 64'(0));
        rs_done[3] = 1'b1;
        run(8);
        check("t2_pops", 64'(pop_cyc.size()), 64'(2));
        if (pop_cyc.size() == 2) begin
            check("t2_first", 64'(pop_tag[0]), 64'(3));
            check("t2_second", 64'(pop_tag[1]), 64'(7));
            check("t2_gap", 64'(pop_cyc[1] - pop_cyc[0]), 64'(2));
        end

        // Back-pressure: hold valid/tag/data, dropping rs_done has no effect.
        rs_done = '0;
        rs_done[2] = 1'b1;
        cdb_ready = 1'b0;
        pop_cyc.delete();
        pop_tag.delete();
        push(2);
        wait_valid("t3_valid");
        rs_done[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_hold_valid", 64'(cdb_valid), 64'(1));
            check("t3_hold_tag", 64'(cdb_tag), 64'(2));
            check("t3_hold_data", 64'(cdb_data), 64'(res[2]));
            check("t3_no_pop", 64'(pop), 64'(0));
            step();
        end
        cdb_ready = 1'b1;
        run(4);
        check("t3_single_pop", 64'(pop_cyc.size()), 64'(1));

        // Fill past depth, then push in the same cycle as a pop at full.
        rs_done = '0;
        for (int i = 0; i < 5; i++) begin
            push(i);
            if (i == 3) begin
                check("t4_count4", 64'(count), 64'(4));
                check("t4_full4", 64'(full), 64'(1));
                check("t4_no_ovf_yet", 64'(overflow), 64'(0));
            end
        end
        check("t4_count", 64'(count), 64'(4));
        check("t4_ovf", 64'(overflow), 64'(1));
        rs_done[0] = 1'b1;
        step();
        check("t4_send", 64'(cdb_valid), 64'(1));
        push(9);
        check("t4_count_hold", 64'(count), 64'(4));
        check("t4_ovf_hold", 64'(overflow), 64'(1));

        // Reset while a broadcast is pending.
        rs_done[1] = 1'b1;
        cdb_ready = 1'b0;
        wait_valid("t5_send");
        pop_cyc.delete();
        pop_tag.delete();
        reset = 1'b1;
        cdb_ready = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("t5_valid", 64'(cdb_valid), 64'(0));
        check("t5_count", 64'(count), 64'(0));
        check("t5_ovf", 64'(overflow), 64'(0));
        run(4);
        check("t5_no_pop", 64'(pop_cyc.size()), 64'(0));
        check("t5_idle", 64'(cdb_valid), 64'(0));

        // Eight sequential tags wrap the queue pointers.
        rs_done = '1;
        cdb_ready = 1'b1;
        pop_cyc.delete();
        pop_tag.delete();
        for (int i = 0; i < 8; i++) begin
            push(8 + i);
            step();
        end
        run(10);
        check("t6_pops", 64'(pop_tag.size()), 64'(8));
        if (pop_tag.size() == 8) begin
            for (int i = 0; i < 8; i++) check("t6_order", 64'(pop_tag[i]), 64'(8 + i));
        end
        check("t6_empty", 64'(count), 64'(0));

        // Randomized traffic against the scoreboard.
        for (int t = 0; t < NT; t++) res[t] = $urandom;
        rs_done = NT'($urandom);
        pop_tag.delete();
        pushes = 0;
        repeat (400) begin
            push_seen = (exp_q.size() < FD) && ($urandom_range(0, 2) == 0);
            push_tag  = TW'($urandom);
            cdb_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) rs_done = NT'($urandom);
            if (push_seen) pushes++;
            step();
            push_seen = 1'b0;
        end
        rs_done = '1;
        cdb_ready = 1'b1;
        run(20);
        check("rand_drained", 64'(pop_tag.size()), 64'(pushes));
        check("rand_empty", 64'(empty), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
